// File: rtl/alu_result_bcd.sv
// Sign-magnitude result to packed BCD converter (double dabble, one bit per clock)
// with leading-zero-suppression enables and a registered display sign.
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last conversion
//   SHIFT | adjusting and shifting one magnitude bit per clock
module alu_result_bcd #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      c,
  input  logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] scr_q, scr_d, scr_adj;
  logic [CW-1:0]       cnt_q;
  logic                neg_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                sign_q;
  logic [DIGITS-1:0]   den_q, den_d;
  logic                busy_q, done_q;
  logic [3:0]          nib;
  logic                any_nz;

  // All nibbles are adjusted from their pre-shift values, then the pair shifts.
  always_comb begin
    scr_adj = scr_q;
    nib     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      nib = scr_q[4*k +: 4];
      scr_adj[4*k +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    {scr_d, bin_d} = {scr_adj, bin_q} << 1;

    den_d    = '0;
    den_d[0] = 1'b1;
    any_nz   = 1'b0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      any_nz   = any_nz | (scr_d[4*k +: 4] != 4'd0);
      den_d[k] = any_nz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      den_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            bin_q   <= c;
            scr_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= neg;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q <= scr_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            bcd_q   <= scr_d;
            den_q   <= den_d;
            // A zero magnitude never shows a minus sign.
            sign_q  <= neg_q & (|scr_d);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd      = bcd_q;
  assign sign     = sign_q;
  assign digit_en = den_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Scoreboard bench for alu_result_bcd: decimal reference model, handshake timing model,
// directed scenarios followed by randomized traffic.
module tb_alu_result_bcd;

  localparam int WIDTH  = 12;
  localparam int DIGITS = 4;

  typedef struct packed {
    logic [4*DIGITS-1:0] bcd;
    logic                sign;
    logic [DIGITS-1:0]   den;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [WIDTH-1:0]    c = '0;
  logic                neg = 1'b0;
  logic [4*DIGITS-1:0] bcd;
  logic                sign;
  logic [DIGITS-1:0]   digit_en;
  logic                busy;
  logic                done;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t held = '0;
  int   rem = 0;
  bit   m_done = 1'b0;

  alu_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .c(c), .neg(neg),
    .bcd(bcd), .sign(sign), .digit_en(digit_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_model(int unsigned v, bit n);
    exp_t        e;
    int unsigned r = v;
    longint      p = 10;
    e = '0;
    for (int k = 0; k < DIGITS; k++) begin
      e.bcd[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.den[0] = 1'b1;
    for (int k = 1; k < DIGITS; k++) begin
      e.den[k] = (longint'(v) >= p);
      p = p * 10;
    end
    e.sign = n && (v != 0);
    return e;
  endfunction

  // Handshake model: a start seen while idle yields a result WIDTH edges later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    = 0;
      m_done = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (rem == 0) begin
        if (start) begin
          exp_q.push_back(ref_model(int'(c), neg));
          rem = WIDTH;
        end
      end else begin
        rem = rem - 1;
        if (rem == 0) m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) held = '0;
    checks++;
    if (busy !== (rem != 0) || done !== m_done) begin
      errors++;
      $display("FAIL handshake t=%0t got busy=%b done=%b want busy=%b done=%b",
               $time, busy, done, (rem != 0), m_done);
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done t=%0t no result expected", $time);
      end else begin
        held = exp_q.pop_front();
      end
    end
    checks++;
    if ({bcd, sign, digit_en} !== held) begin
      errors++;
      $display("FAIL outputs t=%0t got bcd=%h sign=%b en=%b want bcd=%h sign=%b en=%b",
               $time, bcd, sign, digit_en, held.bcd, held.sign, held.den);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic conv(input int unsigned v, input bit n);
    tick();
    start = 1'b1;
    c     = WIDTH'(v);
    neg   = n;
    tick();
    start = 1'b0;
    c     = WIDTH'($urandom);
    neg   = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rem != 0 && n < 4 * WIDTH) begin
      tick();
      n++;
    end
    if (rem != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout t=%0t conversion never finished", $time);
    end
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    conv(56, 0);   wait_idle();
    conv(360, 1);  wait_idle();
    conv(0, 1);    wait_idle();
    conv(4095, 0); wait_idle();
    conv(9, 1);    wait_idle();
    conv(1000, 1); wait_idle();

    // Starts during a conversion must be ignored.
    tick(); start = 1'b1; c = 12'd450; neg = 1'b1;
    tick(); start = 1'b0; c = 12'd8;   neg = 1'b0;
    tick();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    wait_idle();

    // Reset in the middle of a conversion.
    conv(1024, 0);
    repeat (4) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    conv(2, 0); wait_idle();

    // Back-to-back: start held through the done cycle.
    tick(); start = 1'b1; c = 12'd28; neg = 1'b0;
    tick(); c = 12'd4;
    repeat (WIDTH + 1) tick();
    start = 1'b0;
    wait_idle();

    for (int i = 0; i < 500; i++) begin
      tick();
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       c = WIDTH'($urandom_range(0, 9));
        1:       c = WIDTH'($urandom_range(0, 999));
        default: c = WIDTH'($urandom);
      endcase
      neg = 1'($urandom);
    end
    start = 1'b0;
    wait_idle();
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d pending results want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
